// File: rtl/sb_pkg.sv
// ---------------------------------------------------------------------------
// sb_pkg
// Shared constants and types for the decode-stage register scoreboard.
//   NUM_GPR   : number of architectural GPRs tracked
//   CNT_W     : width of each per-register pending-write counter
//   reg_idx_t : 3-bit physical register index
//   EAX..EDI  : register encodings used by upstream decode
//   onehot()  : 3->8 decode of a register index, gated by an enable
// ---------------------------------------------------------------------------
package sb_pkg;

  localparam int NUM_GPR = 8;
  localparam int CNT_W   = 2;
  localparam int REG_W   = 3;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  localparam reg_idx_t EAX = 3'd0;
  localparam reg_idx_t ECX = 3'd1;
  localparam reg_idx_t ESP = 3'd4;
  localparam reg_idx_t ESI = 3'd6;
  localparam reg_idx_t EDI = 3'd7;

  // One-hot select of a register, forced to zero when the slot is unused.
  // OR-ing several of these collapses duplicate destinations to one bit.
  function automatic logic [NUM_GPR-1:0] onehot(input reg_idx_t r, input logic en);
    logic [NUM_GPR-1:0] v;
    v    = '0;
    v[r] = en;
    return v;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// ---------------------------------------------------------------------------
// sb_counter
// Pending-write counter for a single GPR.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : one more in-flight write to this register
//   dec        : one in-flight write to this register retired
//   clr        : drop all pending writes (flush); wins over inc/dec
//   cnt        : current pending-write count
//   nz         : count is non-zero (register busy)
//   underflow  : a retire arrived while the count was already zero
// ---------------------------------------------------------------------------
module sb_counter
  import sb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output cnt_t cnt,
  output logic nz,
  output logic underflow
);

  // A lone decrement at zero is reported and the count holds at zero.
  // A simultaneous inc+dec nets to no change, so it can never underflow.
  assign underflow = dec & ~inc & ~clr & (cnt == '0);
  assign nz        = (cnt != '0);

  // Saturating up/down count; the top level already stalls decode before
  // an increment could push past CNT_MAX, so saturation is a safety net.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != CNT_MAX)) begin
      cnt <= cnt + cnt_t'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - cnt_t'(1);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Decode-stage register scoreboard. Counts in-flight writes per GPR, stalls
// decode on read-after-write or counter-overflow hazards, and releases the
// stall as writeback retires the pending writes.
//   clk, rst_n                 : clock, synchronous active-low reset
//   de_v, ex_stall, flush      : decode valid, downstream stall, pipe flush
//   in1..in4 / in*_needed      : decoding instruction's source registers
//   dreg1..dreg3 / ld_reg1..3  : decoding instruction's destinations
//   wb_v, wb_dreg*, wb_ld_reg* : retiring instruction's destinations
//   dep_stall, issue           : combinational hold / issue strobes
//   reg_busy                   : per-register "write pending" flags
//   sb_err                     : sticky underflow indication
// ---------------------------------------------------------------------------
module reg_scoreboard
  import sb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de_v,
  input  logic               ex_stall,
  input  logic               flush,
  input  logic               in1_needed,
  input  logic               in2_needed,
  input  logic               in3_needed,
  input  logic               in4_needed,
  input  reg_idx_t           in1,
  input  reg_idx_t           in2,
  input  reg_idx_t           in3,
  input  reg_idx_t           in4,
  input  reg_idx_t           dreg1,
  input  reg_idx_t           dreg2,
  input  reg_idx_t           dreg3,
  input  logic               ld_reg1,
  input  logic               ld_reg2,
  input  logic               ld_reg3,
  input  logic               wb_v,
  input  reg_idx_t           wb_dreg1,
  input  reg_idx_t           wb_dreg2,
  input  reg_idx_t           wb_dreg3,
  input  logic               wb_ld_reg1,
  input  logic               wb_ld_reg2,
  input  logic               wb_ld_reg3,
  output logic               dep_stall,
  output logic               issue,
  output logic [NUM_GPR-1:0] reg_busy,
  output logic               sb_err
);

  cnt_t               cnt [NUM_GPR];
  logic [NUM_GPR-1:0] nz;
  logic [NUM_GPR-1:0] underflow;
  logic [NUM_GPR-1:0] inc_vec;
  logic [NUM_GPR-1:0] dec_vec;
  logic               raw_hazard;
  logic               ovf_hazard;

  // Hazard detection looks only at registered counts: a writeback in the
  // same cycle does not unblock a dependent read until the next cycle.
  always_comb begin
    raw_hazard = (in1_needed & nz[in1]) |
                 (in2_needed & nz[in2]) |
                 (in3_needed & nz[in3]) |
                 (in4_needed & nz[in4]);
    ovf_hazard = (ld_reg1 & (cnt[dreg1] == CNT_MAX)) |
                 (ld_reg2 & (cnt[dreg2] == CNT_MAX)) |
                 (ld_reg3 & (cnt[dreg3] == CNT_MAX));
    dep_stall  = de_v & (raw_hazard | ovf_hazard);
    issue      = de_v & ~ex_stall & ~dep_stall & ~flush;
  end

  // Per-register increment/decrement requests. The OR of one-hot decodes
  // collapses repeated destinations so a register moves by at most one.
  always_comb begin
    inc_vec = onehot(dreg1, ld_reg1 & issue) |
              onehot(dreg2, ld_reg2 & issue) |
              onehot(dreg3, ld_reg3 & issue);
    dec_vec = onehot(wb_dreg1, wb_ld_reg1 & wb_v) |
              onehot(wb_dreg2, wb_ld_reg2 & wb_v) |
              onehot(wb_dreg3, wb_ld_reg3 & wb_v);
  end

  for (genvar r = 0; r < NUM_GPR; r++) begin : g_cnt
    sb_counter u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_vec[r]),
      .dec       (dec_vec[r]),
      .clr       (flush),
      .cnt       (cnt[r]),
      .nz        (nz[r]),
      .underflow (underflow[r])
    );
  end

  assign reg_busy = nz;

  // Underflow means writeback and decode disagree about what is in flight;
  // keep the flag until reset so software/debug can see it happened.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_err <= 1'b0;
    end else if (|underflow) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
// Self-checking bench for reg_scoreboard: directed scenarios plus a random
// run, all checked against a count-per-register reference model.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;
  import sb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       de_v, ex_stall, flush;
  logic       in1_needed, in2_needed, in3_needed, in4_needed;
  logic [2:0] in1, in2, in3, in4;
  logic [2:0] dreg1, dreg2, dreg3;
  logic       ld_reg1, ld_reg2, ld_reg3;
  logic       wb_v;
  logic [2:0] wb_dreg1, wb_dreg2, wb_dreg3;
  logic       wb_ld_reg1, wb_ld_reg2, wb_ld_reg3;
  logic       dep_stall, issue, sb_err;
  logic [7:0] reg_busy;

  int checks = 0;
  int errors = 0;

  int m_cnt [8];
  bit m_err;

  reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .de_v(de_v), .ex_stall(ex_stall), .flush(flush),
    .in1_needed(in1_needed), .in2_needed(in2_needed),
    .in3_needed(in3_needed), .in4_needed(in4_needed),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .dreg1(dreg1), .dreg2(dreg2), .dreg3(dreg3),
    .ld_reg1(ld_reg1), .ld_reg2(ld_reg2), .ld_reg3(ld_reg3),
    .wb_v(wb_v), .wb_dreg1(wb_dreg1), .wb_dreg2(wb_dreg2), .wb_dreg3(wb_dreg3),
    .wb_ld_reg1(wb_ld_reg1), .wb_ld_reg2(wb_ld_reg2), .wb_ld_reg3(wb_ld_reg3),
    .dep_stall(dep_stall), .issue(issue), .reg_busy(reg_busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  // Reference model: decode stalls if any needed source has writes pending
  // or any written destination already has three writes pending.
  function automatic bit m_stall();
    bit h;
    h = 1'b0;
    if (in1_needed && m_cnt[in1] != 0) h = 1'b1;
    if (in2_needed && m_cnt[in2] != 0) h = 1'b1;
    if (in3_needed && m_cnt[in3] != 0) h = 1'b1;
    if (in4_needed && m_cnt[in4] != 0) h = 1'b1;
    if (ld_reg1 && m_cnt[dreg1] == 3) h = 1'b1;
    if (ld_reg2 && m_cnt[dreg2] == 3) h = 1'b1;
    if (ld_reg3 && m_cnt[dreg3] == 3) h = 1'b1;
    return de_v && h;
  endfunction

  function automatic bit m_issue();
    return de_v && !ex_stall && !flush && !m_stall();
  endfunction

  function automatic logic [7:0] m_busy();
    logic [7:0] b;
    for (int r = 0; r < 8; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  // Advance one clock and apply the same edge to the model. Inputs only
  // change at the negedge, so sampling them here matches what the DUT sees.
  task automatic tick();
    bit iss;
    bit incs [8];
    bit decs [8];
    iss = m_issue();
    for (int r = 0; r < 8; r++) begin
      incs[r] = 1'b0;
      decs[r] = 1'b0;
    end
    if (iss) begin
      if (ld_reg1) incs[dreg1] = 1'b1;
      if (ld_reg2) incs[dreg2] = 1'b1;
      if (ld_reg3) incs[dreg3] = 1'b1;
    end
    if (wb_v) begin
      if (wb_ld_reg1) decs[wb_dreg1] = 1'b1;
      if (wb_ld_reg2) decs[wb_dreg2] = 1'b1;
      if (wb_ld_reg3) decs[wb_dreg3] = 1'b1;
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int r = 0; r < 8; r++) m_cnt[r] = 0;
      m_err = 1'b0;
    end else if (flush) begin
      for (int r = 0; r < 8; r++) m_cnt[r] = 0;
    end else begin
      for (int r = 0; r < 8; r++) begin
        if (incs[r] && !decs[r]) begin
          m_cnt[r] = m_cnt[r] + 1;
        end else if (decs[r] && !incs[r]) begin
          if (m_cnt[r] == 0) m_err = 1'b1;
          else m_cnt[r] = m_cnt[r] - 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1'b1; de_v = 0; ex_stall = 0; flush = 0;
    in1_needed = 0; in2_needed = 0; in3_needed = 0; in4_needed = 0;
    in1 = 0; in2 = 0; in3 = 0; in4 = 0;
    dreg1 = 0; dreg2 = 0; dreg3 = 0; ld_reg1 = 0; ld_reg2 = 0; ld_reg3 = 0;
    wb_v = 0; wb_dreg1 = 0; wb_dreg2 = 0; wb_dreg3 = 0;
    wb_ld_reg1 = 0; wb_ld_reg2 = 0; wb_ld_reg3 = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (reg_busy !== 8'h00) begin errors++; $display("[TB] FAIL reset_busy: got %h expected 00", reg_busy); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", sb_err); end
    de_v = 1; in3 = EAX; in3_needed = 1;
    #1;
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", dep_stall); end
    checks++; if (issue !== 1'b1) begin errors++; $display("[TB] FAIL reset_issue: got %b expected 1", issue); end
    tick();
    checks++; if (reg_busy !== 8'h00) begin errors++; $display("[TB] FAIL reset_busy2: got %h expected 00", reg_busy); end
  endtask

  task automatic test_raw_hazard();
    idle(); de_v = 1; ld_reg1 = 1; dreg1 = 3'd3;
    #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("[TB] FAIL raw_issue_wr: got %b expected 1", issue); end
    tick();
    checks++; if (reg_busy !== 8'h08) begin errors++; $display("[TB] FAIL raw_busy: got %h expected 08", reg_busy); end
    idle(); de_v = 1; in4 = 3'd3; in4_needed = 1;
    wb_v = 1; wb_dreg1 = 3'd3; wb_ld_reg1 = 1;
    #1;
    checks++; if (dep_stall !== 1'b1) begin errors++; $display("[TB] FAIL raw_stall: got %b expected 1", dep_stall); end
    checks++; if (issue !== 1'b0) begin errors++; $display("[TB] FAIL raw_noissue: got %b expected 0", issue); end
    tick();
    checks++; if (reg_busy !== 8'h00) begin errors++; $display("[TB] FAIL raw_busy_clr: got %h expected 00", reg_busy); end
    wb_v = 0; wb_ld_reg1 = 0;
    #1;
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("[TB] FAIL raw_release: got %b expected 0", dep_stall); end
    checks++; if (issue !== 1'b1) begin errors++; $display("[TB] FAIL raw_issue_rd: got %b expected 1", issue); end
    tick();
  endtask

  task automatic test_overflow();
    idle(); de_v = 1; ld_reg1 = 1; dreg1 = ECX;
    repeat (3) begin
      #1;
      checks++; if (issue !== 1'b1) begin errors++; $display("[TB] FAIL ovf_fill: got %b expected 1", issue); end
      tick();
    end
    #1;
    checks++; if (dep_stall !== 1'b1) begin errors++; $display("[TB] FAIL ovf_stall: got %b expected 1", dep_stall); end
    checks++; if (reg_busy !== 8'h02) begin errors++; $display("[TB] FAIL ovf_busy: got %h expected 02", reg_busy); end
    wb_v = 1; wb_dreg1 = ECX; wb_ld_reg1 = 1;
    tick();
    wb_v = 0; wb_ld_reg1 = 0;
    #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("[TB] FAIL ovf_release: got %b expected 1", issue); end
    tick();
    idle(); wb_v = 1; wb_dreg1 = ECX; wb_ld_reg1 = 1;
    repeat (3) tick();
    idle();
    #1;
    checks++; if (reg_busy !== 8'h00 || sb_err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drain: got busy %h err %b expected 00/0", reg_busy, sb_err); end
  endtask

  task automatic test_inc_dec_same();
    idle(); de_v = 1; ld_reg1 = 1; dreg1 = ESP;
    tick();
    wb_v = 1; wb_dreg1 = ESP; wb_ld_reg1 = 1;
    tick();
    checks++; if (reg_busy !== 8'h10) begin errors++; $display("[TB] FAIL same_busy: got %h expected 10", reg_busy); end
    idle(); wb_v = 1; wb_dreg1 = ESP; wb_ld_reg1 = 1;
    tick();
    checks++; if (reg_busy !== 8'h00 || sb_err !== 1'b0) begin errors++; $display("[TB] FAIL same_net0: got busy %h err %b expected 00/0", reg_busy, sb_err); end
  endtask

  task automatic test_dup_underflow();
    idle(); de_v = 1; ld_reg1 = 1; ld_reg2 = 1; dreg1 = EAX; dreg2 = EAX;
    tick();
    checks++; if (reg_busy !== 8'h01) begin errors++; $display("[TB] FAIL dup_busy: got %h expected 01", reg_busy); end
    idle(); wb_v = 1; wb_dreg1 = EAX; wb_ld_reg1 = 1;
    tick();
    checks++; if (reg_busy !== 8'h00 || sb_err !== 1'b0) begin errors++; $display("[TB] FAIL dup_single: got busy %h err %b expected 00/0", reg_busy, sb_err); end
    tick();
    checks++; if (reg_busy !== 8'h00 || sb_err !== 1'b1) begin errors++; $display("[TB] FAIL underflow: got busy %h err %b expected 00/1", reg_busy, sb_err); end
  endtask

  task automatic test_flush();
    idle(); de_v = 1; ld_reg1 = 1; ld_reg2 = 1; dreg1 = ESI; dreg2 = EDI;
    tick();
    checks++; if (reg_busy !== 8'hC0) begin errors++; $display("[TB] FAIL flush_busy: got %h expected c0", reg_busy); end
    idle(); de_v = 1; in1 = ESI; in1_needed = 1; ld_reg1 = 1; dreg1 = 3'd2;
    #1;
    checks++; if (dep_stall !== 1'b1) begin errors++; $display("[TB] FAIL flush_prestall: got %b expected 1", dep_stall); end
    flush = 1;
    #1;
    checks++; if (issue !== 1'b0) begin errors++; $display("[TB] FAIL flush_issue: got %b expected 0", issue); end
    tick();
    flush = 0;
    #1;
    checks++; if (reg_busy !== 8'h00) begin errors++; $display("[TB] FAIL flush_clr: got %h expected 00", reg_busy); end
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall: got %b expected 0", dep_stall); end
    checks++; if (sb_err !== 1'b1) begin errors++; $display("[TB] FAIL flush_err: got %b expected 1", sb_err); end
    idle(); de_v = 1; ld_reg1 = 1; dreg1 = 3'd2; flush = 1;
    #1;
    checks++; if (issue !== 1'b0) begin errors++; $display("[TB] FAIL flush_gate: got %b expected 0", issue); end
    tick();
    checks++; if (reg_busy !== 8'h00) begin errors++; $display("[TB] FAIL flush_noinc: got %h expected 00", reg_busy); end
  endtask

  task automatic test_reset_mid_stall();
    idle(); de_v = 1; ld_reg1 = 1; dreg1 = 3'd5;
    tick();
    idle(); de_v = 1; in2 = 3'd5; in2_needed = 1;
    #1;
    checks++; if (dep_stall !== 1'b1) begin errors++; $display("[TB] FAIL rst_stall: got %b expected 1", dep_stall); end
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    checks++; if (reg_busy !== 8'h00 || sb_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_state: got busy %h err %b expected 00/0", reg_busy, sb_err); end
    checks++; if (issue !== 1'b1) begin errors++; $display("[TB] FAIL rst_issue: got %b expected 1", issue); end
    tick();
  endtask

  task automatic test_back_to_back();
    idle(); de_v = 1; ld_reg1 = 1;
    for (int i = 0; i < 8; i++) begin
      dreg1 = 3'(i);
      #1;
      checks++; if (issue !== 1'b1) begin errors++; $display("[TB] FAIL b2b_issue%0d: got %b expected 1", i, issue); end
      tick();
    end
    checks++; if (reg_busy !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_busy: got %h expected ff", reg_busy); end
    idle(); wb_v = 1; wb_ld_reg1 = 1;
    for (int i = 0; i < 8; i++) begin
      wb_dreg1 = 3'(i);
      tick();
    end
    idle();
    checks++; if (reg_busy !== 8'h00) begin errors++; $display("[TB] FAIL b2b_drain: got %h expected 00", reg_busy); end
  endtask

  task automatic test_random();
    idle(); rst_n = 0;
    tick();
    rst_n = 1;
    for (int n = 0; n < 400; n++) begin
      de_v = ($urandom_range(3) != 0);
      ex_stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(15) == 0);
      in1_needed = ($urandom_range(2) == 0); in1 = 3'($urandom_range(7));
      in2_needed = ($urandom_range(2) == 0); in2 = 3'($urandom_range(7));
      in3_needed = ($urandom_range(3) == 0); in3 = 3'($urandom_range(7));
      in4_needed = ($urandom_range(3) == 0); in4 = 3'($urandom_range(7));
      ld_reg1 = ($urandom_range(1) == 0); dreg1 = 3'($urandom_range(7));
      ld_reg2 = ($urandom_range(2) == 0); dreg2 = 3'($urandom_range(7));
      ld_reg3 = ($urandom_range(3) == 0); dreg3 = 3'($urandom_range(7));
      wb_v = ($urandom_range(1) == 0);
      wb_ld_reg1 = ($urandom_range(1) == 0); wb_dreg1 = 3'($urandom_range(7));
      wb_ld_reg2 = ($urandom_range(2) == 0); wb_dreg2 = 3'($urandom_range(7));
      wb_ld_reg3 = ($urandom_range(3) == 0); wb_dreg3 = 3'($urandom_range(7));
      #1;
      checks++; if (dep_stall !== m_stall()) begin errors++; $display("[TB] FAIL rnd_stall@%0d: got %b expected %b", n, dep_stall, m_stall()); end
      checks++; if (issue !== m_issue()) begin errors++; $display("[TB] FAIL rnd_issue@%0d: got %b expected %b", n, issue, m_issue()); end
      tick();
      checks++; if (reg_busy !== m_busy()) begin errors++; $display("[TB] FAIL rnd_busy@%0d: got %h expected %h", n, reg_busy, m_busy()); end
      checks++; if (sb_err !== m_err) begin errors++; $display("[TB] FAIL rnd_err@%0d: got %b expected %b", n, sb_err, m_err); end
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) m_cnt[r] = 0;
    m_err = 1'b0;
    $display("[TB] starting reg_scoreboard bench");
    test_reset();
    test_raw_hazard();
    test_overflow();
    test_inc_dec_same();
    test_dup_underflow();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Decode-stage register scoreboard sitting directly downstream of the decode register-address/dependency logic. It consumes the source register numbers (`in1`..`in4` with `in*_needed`) and destination writes (`dreg1`..`dreg3`, `ld_reg1`..`ld_reg3`). It tracks, per GPR, how many issued instructions still have a pending write. It stalls decode on a read-after-write hazard and releases the stall when writeback retires the pending writes.

## Interface
Parameters:
- `NUM_GPR`, 8: number of architectural GPRs tracked; register index width is 3.
- `CNT_W`, 2: pending-write counter width; maximum count is 3.

Ports:
- `clk`  in  1  clock. One clock; reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `de_v`  in  1  decode holds a valid instruction.
- `ex_stall`  in  1  downstream stage cannot accept an instruction this cycle.
- `flush`  in  1  pipeline flush; drops all pending writes.
- `in1_needed`..`in4_needed`  in  1 each  source k is read.
- `in1`..`in4`  in  3 each  source register index, already physical (8-bit high/low aliasing resolved upstream).
- `dreg1`..`dreg3`  in  3 each  destination register index of the decoding instruction.
- `ld_reg1`..`ld_reg3`  in  1 each  destination k is written.
- `wb_v`  in  1  writeback retires one instruction.
- `wb_dreg1`..`wb_dreg3`  in  3 each  retiring destination indices.
- `wb_ld_reg1`..`wb_ld_reg3`  in  1 each  retiring destination k is written.
- `dep_stall`  out  1  combinational; decode must hold.
- `issue`  out  1  combinational; `de_v & ~ex_stall & ~dep_stall & ~flush`.
- `reg_busy`  out  8  registered; bit r is set when count[r] != 0.
- `sb_err`  out  1  registered, sticky; underflow was detected.

## Operation
- State: one `CNT_W`-bit counter per GPR, `count[0..7]`.
- Raw hazard: for each k, `ink_needed & (count[ink] != 0)`.
- Overflow hazard: for each asserted `ld_regk`, `count[dregk] == 3`.
- `dep_stall` = `de_v & (raw hazard | overflow hazard)`. The check uses registered counts only; there is no same-cycle writeback bypass.
- Issue increment: when `issue` is high, each distinct register named by an asserted `ld_regk` is incremented by exactly 1. Duplicates are collapsed, e.g. `dreg1 == dreg2` with both loads set gives +1.
- Writeback decrement: when `wb_v` is high, each distinct register named by an asserted `wb_ld_regk` is decremented by 1, with the same collapsing rule.
- Same register receiving an increment and a decrement in one cycle: net 0, no change.
- Decrement of a register at count 0: the count stays 0 and `sb_err` is set. `sb_err` clears only on reset.
- `flush`: all counts go to 0 on the next edge. Flush has priority over same-cycle increment and decrement, `issue` is forced low, and `sb_err` is unaffected.
- Stack ops (ESP, index 4), string ops (ESI/EDI) and REPNE (ECX) need no special handling; upstream presents them as ordinary `dreg`/`ld_reg` pairs.

## Timing
- Reset (`rst_n == 0` at a posedge): all counts 0, `reg_busy` = 8'h00, `sb_err` = 0. `dep_stall` is then a function of inputs only and is 0, since all counts are 0.
- Reset asserted mid-stall: all state clears at that edge, and the held instruction issues on the first cycle after reset if `de_v` is high.
- Counter and `reg_busy` updates take effect at the posedge following `issue` or `wb_v`.
- A dependent instruction issues no earlier than 1 cycle after the retiring writeback cycle.
- Back-to-back independent issues run at 1 per cycle.
- `dep_stall` and `issue` have no registered latency; their paths run from state and decode inputs only.

## Structure
- Shared package `sb_pkg`:
  - `NUM_GPR`, `CNT_W`;
  - register encodings `EAX`=0, `ECX`=1, `ESP`=4, `ESI`=6, `EDI`=7;
  - a typedef for a 3-bit register index.
- Sub-module `sb_counter`: saturating up/down counter with inputs `inc`, `dec`, `clr` and outputs `cnt`, `nz`, `underflow`. It is instantiated `NUM_GPR` times.
- Top level `reg_scoreboard` contains:
  - 3→8 one-hot decode with OR-collapse for the issue and writeback sets;
  - 4-way source hazard mux;
  - the `sb_err` flop.

## Test plan
- Reset, then present `de_v`=1, `in3`=0 needed, no counts set → `dep_stall`=0, `issue`=1, `reg_busy`=8'h00.
- Issue a write to `dreg1`=3; next cycle decode reads `in4`=3 → `dep_stall`=1. Assert `wb_v` with `wb_dreg1`=3 → `reg_busy[3]` clears the following cycle, and the instruction issues the cycle after that.
- Issue 3 writes to ECX (1) with no writeback, then a 4th instruction writing ECX → 4th stalls on overflow with count[1]=3. One writeback → count=2 and the 4th issues.
- Same cycle: issue writes ESP (4) while `wb_v` retires ESP at count 1 → count stays 1 and `reg_busy[4]`=1.
- `dreg1`=`dreg2`=0 with both loads set → count[0]=1. One writeback with `wb_ld_reg1`=1 for EAX → count 0, `sb_err`=0. A second such writeback → `sb_err`=1 and the count stays 0.
- Counts 6 and 7 busy, decode stalled, `flush`=1 with `issue` suppressed → next cycle `reg_busy`=8'h00 and `dep_stall`=0.
